// File: rtl/uart_tx_cfg.sv
// UART transmitter with a built-in TX FIFO; run-time parity (none/even/odd) and 1/2 stop bits.
// Write-to-line: 1 clock from push into an idle, empty FIFO; wr_ready drops while the FIFO is full.
module uart_tx_cfg #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk_50MHz,
   input  logic                               reset_n,
   input  logic                               sample_tick,
   input  logic                               wr_valid,
   input  logic [DATA_BITS-1:0]               wr_data,
   output logic                               wr_ready,
   input  logic [1:0]                         parity_mode,
   input  logic                               two_stop,
   output logic                               tx,
   output logic                               tx_busy,
   output logic                               tx_done_tick,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   output logic                               fifo_empty
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(2 * OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TS_LAST  = TW'(2 * OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q;
   logic                 push, pop;
   logic [DATA_BITS-1:0] head;

   state_e               state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 par_en_q, par_en_d;
   logic                 two_stop_q, two_stop_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 bit_end;

   assign wr_ready     = (count_q != FULL_CNT);
   assign fifo_empty   = (count_q == '0);
   assign fifo_count   = count_q;
   assign push         = wr_valid && wr_ready;
   assign head         = mem_q[rd_ptr_q];
   assign tx           = tx_q;
   assign tx_busy      = (state_q != S_IDLE);
   assign tx_done_tick = done_q;

   always_ff @(posedge clk_50MHz) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // The stop period is the only bit that may span two OVERSAMPLE windows.
   assign bit_end = sample_tick &&
                    (tick_q == ((state_q == S_STOP && two_stop_q) ? TS_LAST : OS_LAST));

   always_comb begin
      state_d    = state_q;
      tick_d     = sample_tick ? tick_q + TW'(1) : tick_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      par_en_d   = par_en_q;
      two_stop_d = two_stop_q;
      done_d     = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            tick_d = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shreg_d    = head;
               par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
               two_stop_d = two_stop;
               par_d      = (^head) ^ (parity_mode == 2'b10);
               state_d    = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               tick_d    = '0;
               bit_cnt_d = '0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               tick_d  = '0;
               shreg_d = {1'b1, shreg_q[DATA_BITS-1:1]};
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               tick_d  = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               tick_d = '0;
               done_d = 1'b1;
               // Chain straight into the next start bit so queued frames leave no idle gap.
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shreg_d    = head;
                  par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                  two_stop_d = two_stop;
                  par_d      = (^head) ^ (parity_mode == 2'b10);
                  state_d    = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shreg_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         tick_q     <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '1;
         par_q      <= 1'b0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         par_en_q   <= par_en_d;
         two_stop_q <= two_stop_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: table of frame configurations plus hand sequences for FIFO-full,
// reset mid-frame and push/pop on the stop boundary; a negedge line monitor scores every frame.
module tb_uart_tx_cfg;

   logic       clk_50MHz;
   logic       reset_n;
   logic       sample_tick;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic [1:0] parity_mode;
   logic       two_stop;
   logic       tx;
   logic       tx_busy;
   logic       tx_done_tick;
   logic [2:0] fifo_count;
   logic       fifo_empty;

   uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
      .clk_50MHz    (clk_50MHz),
      .reset_n      (reset_n),
      .sample_tick  (sample_tick),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .parity_mode  (parity_mode),
      .two_stop     (two_stop),
      .tx           (tx),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick),
      .fifo_count   (fifo_count),
      .fifo_empty   (fifo_empty)
   );

   initial begin
      clk_50MHz = 1'b0;
      forever #5 clk_50MHz = ~clk_50MHz;
   end

   // Baud strobe on every other clock, changed just after the rising edge.
   initial begin
      int tcnt;
      tcnt = 0;
      sample_tick = 1'b0;
      forever begin
         @(posedge clk_50MHz);
         #1;
         tcnt++;
         sample_tick = tcnt[0];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] pm;
      logic       ts;
   } sb_t;

   sb_t sbq[$];

   // Line monitor / scoreboard
   logic       in_frame = 1'b0;
   logic       ended;
   int         tick_n, cur_len, nb, ferr, idx;
   int         frames_done = 0;
   int         b2b_cnt = 0;
   int         last_ticks = 0;
   logic [7:0] last_data;
   logic       last_par;
   logic       exp_bits [12];
   logic       cap      [12];
   logic       has_par;
   sb_t        cur;

   always @(negedge clk_50MHz) begin
      if (!reset_n) begin
         in_frame = 1'b0;
      end else begin
         ended = 1'b0;
         if (tx_done_tick) begin
            if (in_frame) begin
               check("frame_len", tick_n, cur_len);
               check("frame_bits", ferr, 0);
               last_ticks = tick_n;
               for (int i = 0; i < 8; i++) last_data[i] = cap[i+1];
               last_par = cap[9];
               frames_done++;
               in_frame = 1'b0;
               ended = 1'b1;
            end else begin
               check("spurious_done", 1, 0);
            end
         end
         if (!in_frame && tx === 1'b0) begin
            if (sbq.size() == 0) begin
               check("unexpected_frame", 1, 0);
               cur = '0;
            end else begin
               cur = sbq.pop_front();
            end
            has_par = (cur.pm == 2'b01) || (cur.pm == 2'b10);
            nb = 1 + 8 + (has_par ? 1 : 0) + (cur.ts ? 2 : 1);
            for (int i = 0; i < 12; i++) begin
               exp_bits[i] = 1'b1;
               cap[i] = 1'bx;
            end
            exp_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[i+1] = cur.d[i];
            if (has_par) exp_bits[9] = (^cur.d) ^ (cur.pm == 2'b10);
            cur_len = 16 * nb;
            tick_n = 0;
            ferr = 0;
            in_frame = 1'b1;
            if (ended) b2b_cnt++;
         end
         if (in_frame && sample_tick) begin
            idx = tick_n / 16;
            if (idx < nb) begin
               if (tx !== exp_bits[idx]) ferr++;
               if (tick_n % 16 == 8) cap[idx] = tx;
            end else begin
               ferr++;
            end
            tick_n++;
            if (tick_n > cur_len + 64) begin
               check("frame_overrun", tick_n, cur_len);
               in_frame = 1'b0;
            end
         end
      end
   end

   task automatic push_word(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                            output logic acc);
      @(negedge clk_50MHz);
      parity_mode = pm;
      two_stop    = ts;
      wr_valid    = 1'b1;
      wr_data     = d;
      acc         = wr_ready;
      if (acc) sbq.push_back('{d: d, pm: pm, ts: ts});
      @(posedge clk_50MHz);
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n;
      n = 0;
      while (frames_done < target && n < budget) begin
         @(posedge clk_50MHz);
         n++;
      end
      if (frames_done < target) check("frame_timeout", frames_done, target);
   endtask

   typedef struct {
      logic [7:0] d;
      logic [1:0] pm;
      logic       ts;
      logic       par;
      int         ticks;
   } vec_t;

   vec_t vt[9];

   initial begin
      logic acc;
      int   base, b0, peak, nacc, zeros, n;
      logic rdy6;

      vt[0] = '{d: 8'h55, pm: 2'b00, ts: 1'b0, par: 1'b0, ticks: 160};
      vt[1] = '{d: 8'hA5, pm: 2'b01, ts: 1'b0, par: 1'b0, ticks: 176};
      vt[2] = '{d: 8'hA5, pm: 2'b10, ts: 1'b0, par: 1'b1, ticks: 176};
      vt[3] = '{d: 8'hA5, pm: 2'b10, ts: 1'b1, par: 1'b1, ticks: 192};
      vt[4] = '{d: 8'h3C, pm: 2'b11, ts: 1'b0, par: 1'b0, ticks: 160};
      vt[5] = '{d: 8'h00, pm: 2'b01, ts: 1'b1, par: 1'b0, ticks: 192};
      vt[6] = '{d: 8'hFF, pm: 2'b10, ts: 1'b0, par: 1'b1, ticks: 176};
      vt[7] = '{d: 8'h80, pm: 2'b01, ts: 1'b0, par: 1'b1, ticks: 176};
      vt[8] = '{d: 8'h01, pm: 2'b00, ts: 1'b1, par: 1'b0, ticks: 176};

      reset_n     = 1'b0;
      wr_valid    = 1'b0;
      wr_data     = 8'h00;
      parity_mode = 2'b00;
      two_stop    = 1'b0;
      repeat (3) @(posedge clk_50MHz);
      #2;
      check("rst_tx", tx, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done_tick, 0);
      check("rst_count", fifo_count, 0);
      check("rst_empty", fifo_empty, 1);
      check("rst_ready", wr_ready, 1);
      @(negedge clk_50MHz);
      reset_n = 1'b1;
      repeat (2) @(posedge clk_50MHz);

      // Table-driven single frames; config is flipped mid-frame and must not matter.
      foreach (vt[i]) begin
         base = frames_done;
         push_word(vt[i].d, vt[i].pm, vt[i].ts, acc);
         check("push_acc", acc, 1);
         check("lat_pre_tx", tx, 1);
         check("lat_pre_busy", tx_busy, 0);
         check("lat_pre_count", fifo_count, 1);
         @(posedge clk_50MHz);
         #1;
         check("lat_tx_low", tx, 0);
         check("lat_busy", tx_busy, 1);
         check("lat_popped", fifo_count, 0);
         two_stop    = ~two_stop;
         parity_mode = parity_mode ^ 2'b11;
         wait_frames(base + 1, 1500);
         check("vec_ticks", last_ticks, vt[i].ticks);
         check("vec_data", last_data, vt[i].d);
         if (vt[i].pm == 2'b01 || vt[i].pm == 2'b10) check("vec_parity", last_par, vt[i].par);
         @(posedge clk_50MHz);
         #1;
         check("post_busy", tx_busy, 0);
         check("post_tx", tx, 1);
      end

      // FIFO full with wr_valid held for six cycles, then five back-to-back frames.
      base = frames_done;
      b0   = b2b_cnt;
      peak = 0;
      nacc = 0;
      rdy6 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_50MHz);
         parity_mode = 2'b00;
         two_stop    = 1'b0;
         wr_valid    = 1'b1;
         wr_data     = 8'(i + 1);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
         if (i == 5) rdy6 = wr_ready;
         if (wr_ready) begin
            nacc++;
            sbq.push_back('{d: 8'(i + 1), pm: 2'b00, ts: 1'b0});
         end
      end
      @(posedge clk_50MHz);
      #1;
      wr_valid = 1'b0;
      check("full_accepted", nacc, 5);
      check("full_ready6", rdy6, 0);
      check("full_peak", peak, 4);
      check("full_count", fifo_count, 4);
      wait_frames(base + 5, 3000);
      check("full_frames", frames_done - base, 5);
      check("full_b2b", b2b_cnt - b0, 4);
      check("full_last", last_data, 8'h05);
      check("full_empty", fifo_empty, 1);

      // Reset during DATA of 0x3C with one more word queued.
      push_word(8'h3C, 2'b00, 1'b0, acc);
      push_word(8'h11, 2'b00, 1'b0, acc);
      n = 0;
      while (!(in_frame && cur.d == 8'h3C && tick_n >= 48) && n < 1000) begin
         @(negedge clk_50MHz);
         #1;
         n++;
      end
      check("rst_reach_data", (in_frame && tick_n >= 48), 1);
      check("rst_pre_count", fifo_count, 1);
      base = frames_done;
      #1;
      reset_n = 1'b0;
      #1;
      check("mid_rst_tx", tx, 1);
      check("mid_rst_busy", tx_busy, 0);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_ready", wr_ready, 1);
      sbq.delete();
      repeat (3) @(negedge clk_50MHz);
      reset_n = 1'b1;
      zeros = 0;
      repeat (400) begin
         @(negedge clk_50MHz);
         #1;
         if (tx !== 1'b1 || tx_busy !== 1'b0) zeros++;
      end
      check("post_rst_quiet", zeros, 0);
      check("post_rst_no_done", frames_done, base);
      push_word(8'h3C, 2'b00, 1'b0, acc);
      wait_frames(base + 1, 1500);
      check("post_rst_frame", last_data, 8'h3C);

      // Push on the very edge that ends STOP while one word waits.
      base = frames_done;
      b0   = b2b_cnt;
      push_word(8'hA1, 2'b01, 1'b0, acc);
      push_word(8'hB2, 2'b01, 1'b0, acc);
      check("sim_pending", fifo_count, 1);
      n = 0;
      while (!(in_frame && cur.d == 8'hA1 && tick_n == cur_len) && n < 1500) begin
         @(negedge clk_50MHz);
         #1;
         n++;
      end
      check("sim_found_end", (in_frame && tick_n == cur_len), 1);
      wr_valid = 1'b1;
      wr_data  = 8'hC3;
      check("sim_ready", wr_ready, 1);
      if (wr_ready) sbq.push_back('{d: 8'hC3, pm: 2'b01, ts: 1'b0});
      @(posedge clk_50MHz);
      #1;
      wr_valid = 1'b0;
      check("sim_count", fifo_count, 1);
      check("sim_done", tx_done_tick, 1);
      check("sim_no_gap", tx, 0);
      check("sim_busy", tx_busy, 1);
      wait_frames(base + 3, 2500);
      check("sim_b2b", b2b_cnt - b0, 2);
      check("sim_last", last_data, 8'hC3);
      check("sim_queue", sbq.size(), 0);

      repeat (5) @(posedge clk_50MHz);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
               n_checks, n_fail);
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable UART transmitter with an integrated transmit FIFO. It is the parametrised successor to the fixed 8N1 transmitter. Data width, oversampling ratio and FIFO depth are set at build time; parity (none/even/odd) and stop-bit count (1/2) are selected at run time. It takes bytes from the system side through a valid/ready write port, buffers them, and emits back-to-back frames on `tx`, paced by the shared ×OVERSAMPLE baud `sample_tick`.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `OVERSAMPLE`, default 16: `sample_tick` pulses per bit period; at least 2.
- `FIFO_DEPTH`, default 4: TX FIFO entries; a power of 2, at least 2.
- `clk_50MHz`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sample_tick`  in  1  one-cycle baud×OVERSAMPLE strobe.
- `wr_valid`  in  1  write request.
- `wr_data`  in  DATA_BITS  word to enqueue.
- `wr_ready`  out  1  FIFO can accept; equals `!fifo_full`.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 reserved (behaves as none).
- `two_stop`  in  1  0: one stop bit, 1: two stop bits.
- `tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  high whenever the FSM is not in IDLE.
- `tx_done_tick`  out  1  one-cycle pulse at the end of each frame.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  number of entries held.
- `fifo_empty`  out  1  `fifo_count == 0`.

## Operation
- FIFO
  - A push happens on an edge where `wr_valid && wr_ready`.
  - A pop is issued only by the FSM when it fetches a frame.
  - Push and pop in the same cycle: count is unchanged.
  - When full, a write is refused even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - **IDLE**: `tx`=1. If `!fifo_empty`, the FSM pops the head into the shift register, latches `parity_mode` and `two_stop`, computes the parity bit, and goes to START.
  - **START**: `tx`=0 for OVERSAMPLE ticks, then DATA with `bit_cnt`=0.
  - **DATA**: `tx`=`shreg[0]`, LSB first. Every OVERSAMPLE ticks the register shifts right with 1 fill. After DATA_BITS bits, the FSM goes to PARITY if the latched mode is 01 or 10, otherwise to STOP.
  - **PARITY**: `tx`=parity bit for OVERSAMPLE ticks, then STOP.
    - Even: XOR of the data bits.
    - Odd: inverse of that XOR.
  - **STOP**: `tx`=1 for OVERSAMPLE ticks (×2 if latched `two_stop`).
    - At the last tick `tx_done_tick` pulses.
    - If `!fifo_empty` at that edge, the FSM pops and enters START directly. There is no idle gap.
    - Otherwise it returns to IDLE.
- Configuration inputs are sampled only at frame fetch. Changes mid-frame affect only the next frame.
- Tick counter: width `$clog2(2*OVERSAMPLE)`. It advances only on `sample_tick` and clears at every bit boundary.
- Reset (`reset_n`=0, at any time including mid-frame) forces these values asynchronously:
  - state IDLE;
  - `tx`=1, `tx_busy`=0, `tx_done_tick`=0;
  - FIFO emptied: `fifo_count`=0, `fifo_empty`=1, `wr_ready`=1.
  - The aborted frame produces no done pulse and is not resumed.

## Timing
- **Write-to-line latency**: push at edge k into an empty FIFO with the FSM in IDLE. The FSM pops at edge k+1, and `tx` falls and `tx_busy` rises at edge k+1.
- **Frame length** in `sample_tick` pulses: OVERSAMPLE × (1 + DATA_BITS + P + S), where P is 0 or 1 and S is 1 or 2.
- **Bit transitions** occur on the clock edge that registers the OVERSAMPLE-th tick of the previous bit. `tx` never glitches.
- **`tx_done_tick`** is high for exactly one clock, on the edge that ends STOP.
  - With back-to-back frames, `tx` goes from 1 (stop) to 0 (start) on that same edge.
  - `tx_busy` stays high throughout.
- **`wr_ready`** updates one edge after the push that fills the FIFO. It rises one edge after the pop that frees a slot.

## Test plan
- **8N1 frame**: 0x55, OVERSAMPLE=16, `parity_mode`=00, `two_stop`=0.
  - Required: `tx` low for 16 ticks, then 1,0,1,0,1,0,1,0 at 16 ticks each, then high for 16 ticks.
  - One `tx_done_tick` pulse after 160 ticks, then `tx_busy`=0.
- **Parity**: 0xA5 with `parity_mode`=01 gives a parity bit of 0; with 10 it gives 1. Frame length is 176 ticks.
- **Two stop bits**: 0xA5 with `parity_mode`=10 and `two_stop`=1.
  - Stop is high for 32 ticks; total 192 ticks.
  - `two_stop` toggled mid-frame does not alter the current frame.
- **FIFO full and back-to-back**: FIFO_DEPTH=4, `wr_valid` held for 6 cycles with words 0x01..0x06.
  - 5 words are accepted; `wr_ready`=0 on the 6th; `fifo_count` peaks at 4.
  - Five frames 0x01..0x05 are emitted with a stop→start transition on the `tx_done_tick` edge.
- **Reset mid-frame**: `reset_n` is pulled low during DATA of frame 0x3C.
  - Immediately: `tx`=1, `tx_busy`=0, `fifo_count`=0.
  - No done pulse occurs, and nothing is transmitted after release until a new write.
- **Simultaneous push/pop**: write the cycle the FSM pops at the end of STOP, with `fifo_count`=1 → `fifo_count` stays 1, and the next frame starts without a gap.
